// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, arbiter states and
// default bus widths used by the arbiter and its pin mux.
package sdram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int BANK_W_DEF = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRECH = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_ARBIT   = 3'd1,
    ST_REFRESH = 3'd2,
    ST_WRITE   = 3'd3,
    ST_READ    = 3'd4
  } arbit_state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational pin mux: picks the init, refresh, write or read bus
// by arbiter state; NOP whenever idle or held in reset.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  arbit_state_t      state,
  input  logic              en,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic [BANK_W-1:0] ref_bank,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic [3:0]        cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [BANK_W-1:0] bank
);

  always_comb begin
    cmd  = CMD_NOP;
    addr = '0;
    bank = '0;
    if (en) begin
      unique case (state)
        ST_INIT: begin
          cmd  = init_cmd;
          addr = init_addr;
          bank = init_bank;
        end
        ST_REFRESH: begin
          cmd  = ref_cmd;
          addr = ref_addr;
          bank = ref_bank;
        end
        ST_WRITE: begin
          cmd  = wr_cmd;
          addr = wr_addr;
          bank = wr_bank;
        end
        ST_READ: begin
          cmd  = rd_cmd;
          addr = rd_addr;
          bank = rd_bank;
        end
        default: begin
          cmd  = CMD_NOP;
          addr = '0;
          bank = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: refresh > write > read, non-preemptive,
// grant held until the owner's end strobe.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BANK_W-1:0] init_bank_addr,
  input  logic              refresh_req,
  output logic              refresh_ack,
  input  logic              refresh_end,
  input  logic [3:0]        refresh_cmd,
  input  logic [ADDR_W-1:0] refresh_addr,
  input  logic [BANK_W-1:0] refresh_bank_addr,
  input  logic              arbit_write_req,
  output logic              arbit_write_ack,
  input  logic              write_end,
  input  logic [3:0]        write_cmd,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [BANK_W-1:0] write_bank_addr,
  input  logic              read_req,
  output logic              read_ack,
  input  logic              read_end,
  input  logic [3:0]        read_cmd,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [BANK_W-1:0] read_bank_addr,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank_addr
);

  arbit_state_t state;
  arbit_state_t state_nxt;

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: begin
        if (init_end) state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (refresh_req)          state_nxt = ST_REFRESH;
        else if (arbit_write_req) state_nxt = ST_WRITE;
        else if (read_req)        state_nxt = ST_READ;
      end
      ST_REFRESH: begin
        if (refresh_end) state_nxt = ST_ARBIT;
      end
      ST_WRITE: begin
        if (write_end) state_nxt = ST_ARBIT;
      end
      ST_READ: begin
        if (read_end) state_nxt = ST_ARBIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign refresh_ack     = (state == ST_REFRESH);
  assign arbit_write_ack = (state == ST_WRITE);
  assign read_ack        = (state == ST_READ);
  assign sdram_cke       = rst_n;

  // rst_n gates the mux so pins fall to NOP without a clock edge
  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W)
  ) u_mux (
    .state     (state),
    .en        (rst_n),
    .init_cmd  (init_cmd),
    .init_addr (init_addr),
    .init_bank (init_bank_addr),
    .ref_cmd   (refresh_cmd),
    .ref_addr  (refresh_addr),
    .ref_bank  (refresh_bank_addr),
    .wr_cmd    (write_cmd),
    .wr_addr   (write_addr),
    .wr_bank   (write_bank_addr),
    .rd_cmd    (read_cmd),
    .rd_addr   (read_addr),
    .rd_bank   (read_bank_addr),
    .cmd       (sdram_cmd),
    .addr      (sdram_addr),
    .bank      (sdram_bank_addr)
  );

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus random traffic,
// checked every cycle against an owner-tracking model.
module tb_sdram_arbit;

  localparam int AW = 13;
  localparam int BW = 2;
  localparam logic [3:0] NOP = 4'b0111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_end;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic [BW-1:0] init_bank;
  logic          refresh_req, refresh_ack, refresh_end;
  logic [3:0]    refresh_cmd;
  logic [AW-1:0] refresh_addr;
  logic [BW-1:0] refresh_bank;
  logic          write_req, write_ack, write_end;
  logic [3:0]    write_cmd;
  logic [AW-1:0] write_addr;
  logic [BW-1:0] write_bank;
  logic          read_req, read_ack, read_end;
  logic [3:0]    read_cmd;
  logic [AW-1:0] read_addr;
  logic [BW-1:0] read_bank;
  logic          cke;
  logic [3:0]    cmd;
  logic [AW-1:0] addr;
  logic [BW-1:0] bank;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbit #(.ADDR_W(AW), .BANK_W(BW)) dut (
    .sysclk_100M       (clk),
    .rst_n             (rst_n),
    .init_end          (init_end),
    .init_cmd          (init_cmd),
    .init_addr         (init_addr),
    .init_bank_addr    (init_bank),
    .refresh_req       (refresh_req),
    .refresh_ack       (refresh_ack),
    .refresh_end       (refresh_end),
    .refresh_cmd       (refresh_cmd),
    .refresh_addr      (refresh_addr),
    .refresh_bank_addr (refresh_bank),
    .arbit_write_req   (write_req),
    .arbit_write_ack   (write_ack),
    .write_end         (write_end),
    .write_cmd         (write_cmd),
    .write_addr        (write_addr),
    .write_bank_addr   (write_bank),
    .read_req          (read_req),
    .read_ack          (read_ack),
    .read_end          (read_end),
    .read_cmd          (read_cmd),
    .read_addr         (read_addr),
    .read_bank_addr    (read_bank),
    .sdram_cke         (cke),
    .sdram_cmd         (cmd),
    .sdram_addr        (addr),
    .sdram_bank_addr   (bank)
  );

  // model: who owns the bus (0 none, 1 refresh, 2 write, 3 read)
  bit m_ready;
  int m_owner;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0;
      m_owner <= 0;
    end else if (!m_ready) begin
      if (init_end) m_ready <= 1'b1;
    end else if (m_owner == 0) begin
      if (refresh_req)    m_owner <= 1;
      else if (write_req) m_owner <= 2;
      else if (read_req)  m_owner <= 3;
    end else if ((m_owner == 1 && refresh_end) ||
                 (m_owner == 2 && write_end) ||
                 (m_owner == 3 && read_end)) begin
      m_owner <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0]    e_cmd;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_bank;
    e_cmd  = NOP;
    e_addr = '0;
    e_bank = '0;
    if (rst_n && !m_ready) begin
      e_cmd = init_cmd; e_addr = init_addr; e_bank = init_bank;
    end else if (rst_n && m_owner == 1) begin
      e_cmd = refresh_cmd; e_addr = refresh_addr; e_bank = refresh_bank;
    end else if (rst_n && m_owner == 2) begin
      e_cmd = write_cmd; e_addr = write_addr; e_bank = write_bank;
    end else if (rst_n && m_owner == 3) begin
      e_cmd = read_cmd; e_addr = read_addr; e_bank = read_bank;
    end
    chk("m_cke", 32'(cke), 32'(rst_n));
    chk("m_ref_ack", 32'(refresh_ack), 32'(rst_n && m_ready && m_owner == 1));
    chk("m_wr_ack", 32'(write_ack), 32'(rst_n && m_ready && m_owner == 2));
    chk("m_rd_ack", 32'(read_ack), 32'(rst_n && m_ready && m_owner == 3));
    chk("m_cmd", 32'(cmd), 32'(e_cmd));
    chk("m_addr", 32'(addr), 32'(e_addr));
    chk("m_bank", 32'(bank), 32'(e_bank));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_buses();
    init_cmd     = 4'($urandom);
    init_addr    = AW'($urandom);
    init_bank    = BW'($urandom);
    refresh_cmd  = 4'($urandom);
    refresh_addr = AW'($urandom);
    refresh_bank = BW'($urandom);
    write_cmd    = 4'($urandom);
    write_addr   = AW'($urandom);
    write_bank   = BW'($urandom);
    read_cmd     = 4'($urandom);
    read_addr    = AW'($urandom);
    read_bank    = BW'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    init_end = 0;
    refresh_req = 0; refresh_end = 0;
    write_req = 0;   write_end = 0;
    read_req = 0;    read_end = 0;
    rand_buses();
    refresh_cmd = 4'b0001;
    write_cmd   = 4'b0100;
    read_cmd    = 4'b0101;

    at_neg();
    chk("rst_cmd", 32'(cmd), 32'(NOP));
    chk("rst_cke", 32'(cke), 32'd0);
    chk("rst_acks", 32'({refresh_ack, write_ack, read_ack}), 32'd0);

    rst_n = 1'b1;
    init_cmd = 4'b0010;
    at_neg();
    chk("init_cmd", 32'(cmd), 32'h2);
    chk("init_cke", 32'(cke), 32'd1);

    write_req = 1;
    step(); step();
    at_neg();
    chk("wr_before_init", 32'(write_ack), 32'd0);
    write_req = 0;
    init_end = 1;
    step();
    at_neg();
    chk("arbit_nop", 32'(cmd), 32'(NOP));

    write_req = 1;
    step();
    at_neg();
    chk("wr_ack", 32'(write_ack), 32'd1);
    chk("wr_cmd", 32'(cmd), 32'h4);
    read_end = 1;
    step();
    read_end = 0;
    at_neg();
    chk("stray_rd_end", 32'(write_ack), 32'd1);
    write_end = 1; write_req = 0;
    step();
    write_end = 0;
    at_neg();
    chk("wr_end_ack", 32'(write_ack), 32'd0);
    chk("wr_end_nop", 32'(cmd), 32'(NOP));

    refresh_req = 1; write_req = 1;
    step();
    at_neg();
    chk("prio_ref", 32'({refresh_ack, write_ack}), 32'b10);
    refresh_end = 1; refresh_req = 0;
    step();
    refresh_end = 0;
    at_neg();
    chk("gap_nop", 32'(cmd), 32'(NOP));
    step();
    at_neg();
    chk("wr_after_ref", 32'(write_ack), 32'd1);

    repeat (6) step();
    refresh_req = 1;
    step(); step();
    at_neg();
    chk("no_preempt", 32'({refresh_ack, write_ack}), 32'b01);
    write_end = 1; write_req = 0;
    step();
    write_end = 0;
    at_neg();
    chk("gap_nop2", 32'(cmd), 32'(NOP));
    step();
    at_neg();
    chk("ref_after_wr", 32'(refresh_ack), 32'd1);
    refresh_end = 1; refresh_req = 0;
    step();
    refresh_end = 0;

    write_req = 1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_ack", 32'(write_ack), 32'd0);
    chk("async_cmd", 32'(cmd), 32'(NOP));
    init_end = 0;
    at_neg();
    rst_n = 1'b1;
    step(); step();
    at_neg();
    chk("need_init", 32'(write_ack), 32'd0);
    init_end = 1;
    step(); step();
    at_neg();
    chk("regrant", 32'(write_ack), 32'd1);
    write_end = 1; write_req = 0;
    step();
    write_end = 0;

    for (int i = 0; i < 4000; i++) begin
      step();
      rand_buses();
      if ($urandom_range(0, 9) == 0) refresh_req = ~refresh_req;
      if ($urandom_range(0, 5) == 0) write_req = ~write_req;
      if ($urandom_range(0, 5) == 0) read_req = ~read_req;
      refresh_end = ($urandom_range(0, 4) == 0);
      write_end   = ($urandom_range(0, 4) == 0);
      read_end    = ($urandom_range(0, 4) == 0);
      init_end    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    at_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
